// File: rtl/nucleo_multiciclo.sv
// Multi-cycle RV32I-subset core: FSM, PC/IR, register file, ALU, instruction and data memory.
// Executes ADDI/ADD/SUB/LW/SW/BEQ/BNE; stops on EBREAK or any unsupported encoding.
module nucleo_multiciclo #(
    parameter int              XLEN       = 32,
    parameter int              IMEM_DEPTH = 64,
    parameter int              DMEM_DEPTH = 64,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    input  logic                          prog_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
    input  logic [31:0]                   prog_data,
    output logic [XLEN-1:0]               pc,
    output logic [31:0]                   inst,
    output logic [XLEN-1:0]               alu_res,
    output logic [XLEN-1:0]               wb_data,
    output logic [2:0]                    state,
    output logic                          halted,
    output logic                          illegal,
    output logic [31:0]                   instret
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    state_t          st;
    logic [31:0]     imem [IMEM_DEPTH];
    logic [XLEN-1:0] regs [32];
    logic [XLEN-1:0] dmem [DMEM_DEPTH];
    logic [XLEN-1:0] a, b, imm, mdr;

    logic [6:0] opcode, funct7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];
    assign state  = st;

    logic is_addi, is_add, is_sub, is_lw, is_sw, is_beq, is_bne, is_ebreak, is_legal;

    always_comb begin
        is_ebreak = (inst == 32'h0010_0073);
        is_addi   = (opcode == 7'b0010011) && (funct3 == 3'b000);
        is_add    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
        is_sub    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
        is_lw     = (opcode == 7'b0000011) && (funct3 == 3'b010);
        is_sw     = (opcode == 7'b0100011) && (funct3 == 3'b010);
        is_beq    = (opcode == 7'b1100011) && (funct3 == 3'b000);
        is_bne    = (opcode == 7'b1100011) && (funct3 == 3'b001);
        is_legal  = is_addi | is_add | is_sub | is_lw | is_sw | is_beq | is_bne;
    end

    logic [XLEN-1:0] imm_i, imm_s, imm_b, alu_out, wb_val;
    logic            br_taken;
    logic [DAW-1:0]  didx;
    logic [IAW-1:0]  iidx;

    assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};

    always_comb begin
        if (is_add)
            alu_out = a + b;
        else if (is_sub)
            alu_out = a - b;
        else
            alu_out = a + imm;
    end

    assign br_taken = is_beq ? (a == b) : (a != b);
    assign wb_val   = is_lw ? mdr : alu_res;
    // Word index only: byte-offset bits are dropped and the index wraps with the memory size.
    assign didx     = alu_res[DAW+1:2];
    assign iidx     = pc[IAW+1:2];

    // Program load shares no cycle with fetch because it is only honoured in IDLE.
    always_ff @(posedge clk) begin
        if (prog_we && st == IDLE)
            imem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= IDLE;
            pc      <= RESET_PC;
            inst    <= '0;
            alu_res <= '0;
            wb_data <= '0;
            halted  <= 1'b0;
            illegal <= 1'b0;
            instret <= '0;
            a       <= '0;
            b       <= '0;
            imm     <= '0;
            mdr     <= '0;
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
            for (int i = 0; i < DMEM_DEPTH; i++)
                dmem[i] <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (run)
                        st <= FETCH;
                end
                FETCH: begin
                    inst <= imem[iidx];
                    st   <= DECODE;
                end
                DECODE: begin
                    a   <= (rs1 == 5'd0) ? '0 : regs[rs1];
                    b   <= (rs2 == 5'd0) ? '0 : regs[rs2];
                    imm <= is_sw ? imm_s : ((is_beq | is_bne) ? imm_b : imm_i);
                    if (is_ebreak) begin
                        halted  <= 1'b1;
                        instret <= instret + 32'd1;
                        st      <= HALT;
                    end else if (!is_legal) begin
                        halted  <= 1'b1;
                        illegal <= 1'b1;
                        st      <= HALT;
                    end else begin
                        st <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_beq | is_bne) begin
                        pc      <= br_taken ? pc + imm : pc + XLEN'(4);
                        instret <= instret + 32'd1;
                        st      <= run ? FETCH : IDLE;
                    end else begin
                        alu_res <= alu_out;
                        st      <= (is_lw | is_sw) ? MEM : WB;
                    end
                end
                MEM: begin
                    if (is_lw) begin
                        mdr <= dmem[didx];
                        st  <= WB;
                    end else begin
                        dmem[didx] <= b;
                        pc         <= pc + XLEN'(4);
                        instret    <= instret + 32'd1;
                        st         <= run ? FETCH : IDLE;
                    end
                end
                WB: begin
                    // x0 stays zero, but the debug port still shows the computed value.
                    if (rd != 5'd0)
                        regs[rd] <= wb_val;
                    wb_data <= wb_val;
                    pc      <= pc + XLEN'(4);
                    instret <= instret + 32'd1;
                    st      <= run ? FETCH : IDLE;
                end
                HALT: st <= HALT;
                default: st <= IDLE;
            endcase
        end
    end
endmodule
